// File: rtl/jc_block_nested.sv
// rtl/jc_block_nested.sv - jump-control unit with nested prioritised interrupts
// Drives the PC mux for jumps/RET and vectors to handlers through a hardware return stack.
module jc_block_nested #(
  parameter int ADDR_W = 16,
  parameter int NUM_IRQ = 4,
  parameter int STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0] VEC_BASE = 'hF000,
  parameter logic [ADDR_W-1:0] VEC_STRIDE = 'h0010
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [ADDR_W-1:0]                  jmp_address_pm,
  input  logic [ADDR_W-1:0]                  current_address,
  input  logic [5:0]                         op,
  input  logic [1:0]                         flag_ex,
  input  logic [NUM_IRQ-1:0]                 irq,
  input  logic                               irq_en,
  output logic [ADDR_W-1:0]                  jmp_loc,
  output logic                               pc_mux_sel,
  output logic [NUM_IRQ-1:0]                 irq_ack,
  output logic [1:0]                         flag_restore,
  output logic                               flag_restore_vld,
  output logic                               stack_full,
  output logic                               stack_err,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   depth
);

  localparam int DW = $clog2(STACK_DEPTH+1);
  localparam int AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int CW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
  localparam logic [DW-1:0] SP_FULL = DW'(STACK_DEPTH);

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] VECTOR     = 2'd1;
  localparam logic [1:0] SAVE_FLAGS = 2'd2;

  localparam logic [5:0] OP_JMP = 6'b011000;
  localparam logic [5:0] OP_RET = 6'b010000;
  localparam logic [5:0] OP_JV  = 6'b011100;
  localparam logic [5:0] OP_JNV = 6'b011101;
  localparam logic [5:0] OP_JZ  = 6'b011110;
  localparam logic [5:0] OP_JNZ = 6'b011111;

  logic [1:0]        state;
  logic [DW-1:0]     sp;
  logic              err;
  logic [ADDR_W-1:0] stk_addr  [STACK_DEPTH];
  logic [1:0]        stk_flags [STACK_DEPTH];
  logic [CW-1:0]     stk_chan  [STACK_DEPTH];

  logic [AW-1:0]     top;
  logic [AW-1:0]     nxt;
  logic [CW-1:0]     top_chan;
  logic [CW-1:0]     win_chan;
  logic              win_found;
  logic              empty;
  logic              accept;

  assign top      = AW'(sp - 1'b1);
  assign nxt      = AW'(sp);
  assign empty    = (sp == '0);
  assign top_chan = stk_chan[top];

  // Only a strictly higher-priority line than the active handler may preempt it.
  always_comb begin
    win_found = 1'b0;
    win_chan  = '0;
    for (int k = 0; k < NUM_IRQ; k++) begin
      if (!win_found && irq[k] && (empty || k < int'(top_chan))) begin
        win_found = 1'b1;
        win_chan  = CW'(k);
      end
    end
  end

  assign accept = (state == IDLE) && irq_en && (op != OP_RET) && (sp != SP_FULL) && win_found;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      sp    <= '0;
      err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (op == OP_RET) begin
            if (empty) err <= 1'b1;
            else       sp  <= sp - 1'b1;
          end else if (accept) begin
            sp    <= sp + 1'b1;
            state <= VECTOR;
          end
        end
        VECTOR:  state <= SAVE_FLAGS;
        default: state <= IDLE;
      endcase
    end
  end

  // Stack contents need no reset; sp alone defines what is live.
  always_ff @(posedge clk) begin
    if (!reset && accept) begin
      stk_addr[nxt] <= current_address + 1'b1;
      stk_chan[nxt] <= win_chan;
    end
    if (!reset && state == SAVE_FLAGS) stk_flags[top] <= flag_ex;
  end

  always_comb begin
    pc_mux_sel       = 1'b0;
    jmp_loc          = '0;
    irq_ack          = '0;
    flag_restore     = 2'b00;
    flag_restore_vld = 1'b0;
    if (!reset) begin
      case (state)
        IDLE: begin
          jmp_loc = jmp_address_pm;
          case (op)
            OP_JMP: pc_mux_sel = 1'b1;
            OP_JV:  pc_mux_sel = flag_ex[0];
            OP_JNV: pc_mux_sel = !flag_ex[0];
            OP_JZ:  pc_mux_sel = flag_ex[1];
            OP_JNZ: pc_mux_sel = !flag_ex[1];
            OP_RET: begin
              if (!empty) begin
                pc_mux_sel       = 1'b1;
                jmp_loc          = stk_addr[top];
                flag_restore     = stk_flags[top];
                flag_restore_vld = 1'b1;
              end
            end
            default: ;
          endcase
        end
        VECTOR: begin
          pc_mux_sel        = 1'b1;
          jmp_loc           = VEC_BASE + VEC_STRIDE * ADDR_W'(top_chan);
          irq_ack[top_chan] = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign stack_full = !reset && (sp == SP_FULL);
  assign stack_err  = !reset && err;
  assign depth      = reset ? '0 : sp;

endmodule

// File: tb/tb_jc_block_nested.sv
// tb/tb_jc_block_nested.sv - self-checking bench for jc_block_nested
// Jump table, directed nesting/stack sequences, then random traffic against a queue-based model.
module tb_jc_block_nested;

  localparam logic [5:0] JMP = 6'b011000;
  localparam logic [5:0] RET = 6'b010000;
  localparam logic [5:0] JV  = 6'b011100;
  localparam logic [5:0] JNV = 6'b011101;
  localparam logic [5:0] JZ  = 6'b011110;
  localparam logic [5:0] JNZ = 6'b011111;
  localparam logic [5:0] NOP = 6'b000000;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] jmp_address_pm, current_address, jmp_loc;
  logic [5:0]  op;
  logic [1:0]  flag_ex, flag_restore;
  logic [3:0]  irq, irq_ack;
  logic        irq_en, pc_mux_sel, flag_restore_vld, stack_full, stack_err;
  logic [2:0]  depth;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [5:0]  op;
    logic [1:0]  fl;
    logic [15:0] jpm;
    logic        sel;
  } vec_t;

  typedef struct {
    logic [15:0] addr;
    logic [1:0]  flags;
    int          chan;
  } frame_t;

  vec_t   tbl [12];
  frame_t stk [$];

  always #5 clk = ~clk;

  jc_block_nested dut (
    .clk(clk), .reset(reset), .jmp_address_pm(jmp_address_pm),
    .current_address(current_address), .op(op), .flag_ex(flag_ex),
    .irq(irq), .irq_en(irq_en), .jmp_loc(jmp_loc), .pc_mux_sel(pc_mux_sel),
    .irq_ack(irq_ack), .flag_restore(flag_restore),
    .flag_restore_vld(flag_restore_vld), .stack_full(stack_full),
    .stack_err(stack_err), .depth(depth)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Accept line k, check the vector cycle, supply flags for the save cycle, return to IDLE.
  task automatic take_irq(input logic [3:0] req, input int k, input logic [15:0] pc,
                          input logic [1:0] fl, input int exp_depth);
    op = NOP; irq = req; irq_en = 1'b1; current_address = pc;
    cyc();
    smp();
    chk("vec_sel", pc_mux_sel, 1'b1);
    chk("vec_loc", jmp_loc, 16'hF000 + 16'(k * 16));
    chk("vec_ack", irq_ack, 4'(1 << k));
    chk("vec_depth", depth, exp_depth);
    irq = req & ~4'(1 << k);
    flag_ex = fl;
    cyc();
    smp();
    chk("save_sel", pc_mux_sel, 1'b0);
    chk("save_ack", irq_ack, 4'b0);
    cyc();
  endtask

  task automatic do_ret(input logic [15:0] exp_addr, input logic [1:0] exp_fl, input int exp_depth);
    op = RET;
    smp();
    chk("ret_sel", pc_mux_sel, 1'b1);
    chk("ret_loc", jmp_loc, exp_addr);
    chk("ret_flags", flag_restore, exp_fl);
    chk("ret_vld", flag_restore_vld, 1'b1);
    cyc();
    op = NOP;
    chk("ret_depth", depth, exp_depth);
  endtask

  initial begin
    logic        e_sel, e_vld, lchk, found;
    logic [15:0] e_loc;
    logic [3:0]  e_ack;
    logic [1:0]  e_fr;
    logic        merr;
    int          phase, n;
    frame_t      fr;

    tbl[0]  = '{JZ,  2'b10, 16'h1111, 1'b1};
    tbl[1]  = '{JZ,  2'b00, 16'h2222, 1'b0};
    tbl[2]  = '{JZ,  2'b01, 16'h3333, 1'b0};
    tbl[3]  = '{JNZ, 2'b00, 16'h4444, 1'b1};
    tbl[4]  = '{JNZ, 2'b10, 16'h5555, 1'b0};
    tbl[5]  = '{JV,  2'b01, 16'h6666, 1'b1};
    tbl[6]  = '{JV,  2'b10, 16'h7777, 1'b0};
    tbl[7]  = '{JNV, 2'b10, 16'h8888, 1'b1};
    tbl[8]  = '{JNV, 2'b01, 16'h9999, 1'b0};
    tbl[9]  = '{JMP, 2'b00, 16'hABCD, 1'b1};
    tbl[10] = '{NOP, 2'b11, 16'hBEEF, 1'b0};
    tbl[11] = '{6'b111111, 2'b11, 16'hCAFE, 1'b0};

    reset = 1'b1; op = JMP; flag_ex = 2'b11; irq = 4'hF; irq_en = 1'b1;
    jmp_address_pm = 16'h1234; current_address = 16'h0010;
    #2;
    chk("rst_sel", pc_mux_sel, 1'b0);
    chk("rst_loc", jmp_loc, 16'h0);
    chk("rst_depth", depth, 3'd0);
    cyc(); cyc();
    irq = 4'b0; irq_en = 1'b0;
    reset = 1'b0;
    smp();
    chk("post_rst_err", stack_err, 1'b0);
    chk("post_rst_full", stack_full, 1'b0);

    for (int i = 0; i < 12; i++) begin
      op = tbl[i].op; flag_ex = tbl[i].fl; jmp_address_pm = tbl[i].jpm;
      smp();
      chk($sformatf("tbl%0d_sel", i), pc_mux_sel, tbl[i].sel);
      chk($sformatf("tbl%0d_loc", i), jmp_loc, tbl[i].jpm);
      cyc();
    end

    // irq[2] at PC 0x0040
    op = NOP; irq = 4'b0100; irq_en = 1'b1; current_address = 16'h0040;
    smp();
    chk("pre_acc_sel", pc_mux_sel, 1'b0);
    chk("pre_acc_ack", irq_ack, 4'b0);
    take_irq(4'b0100, 2, 16'h0040, 2'b01, 1);

    // ch1 preempts ch2; ch3 stays pending
    flag_ex = 2'b00;
    take_irq(4'b1010, 1, 16'h0100, 2'b10, 2);
    for (int i = 0; i < 2; i++) begin
      smp();
      chk("hold3_ack", irq_ack, 4'b0);
      cyc();
      chk("hold3_depth", depth, 3'd2);
    end
    do_ret(16'h0101, 2'b10, 1);
    current_address = 16'h0200;
    smp();
    chk("hold3b_ack", irq_ack, 4'b0);
    cyc();
    chk("hold3b_depth", depth, 3'd1);
    do_ret(16'h0041, 2'b01, 0);
    cyc();
    smp();
    chk("ch3_loc", jmp_loc, 16'hF030);
    chk("ch3_ack", irq_ack, 4'b1000);
    irq = 4'b0; flag_ex = 2'b11;
    cyc(); cyc();

    // fill to four levels
    take_irq(4'b0100, 2, 16'h0300, 2'b00, 2);
    take_irq(4'b0010, 1, 16'h0400, 2'b10, 3);
    take_irq(4'b0001, 0, 16'h0500, 2'b01, 4);
    chk("full_flag", stack_full, 1'b1);
    irq = 4'hF;
    for (int i = 0; i < 3; i++) begin
      smp();
      chk("full_ack", irq_ack, 4'b0);
      cyc();
      chk("full_depth", depth, 3'd4);
    end
    irq = 4'b0;
    do_ret(16'h0501, 2'b01, 3);
    do_ret(16'h0401, 2'b10, 2);
    do_ret(16'h0301, 2'b00, 1);
    do_ret(16'h0201, 2'b11, 0);
    op = RET;
    smp();
    chk("empty_ret_sel", pc_mux_sel, 1'b0);
    chk("empty_ret_vld", flag_restore_vld, 1'b0);
    cyc();
    op = NOP;
    chk("stack_err", stack_err, 1'b1);
    chk("empty_depth", depth, 3'd0);

    // RET and irq[0] together: pop first, accept next cycle
    take_irq(4'b0100, 2, 16'h0600, 2'b10, 1);
    op = RET; irq = 4'b0001;
    smp();
    chk("rr_sel", pc_mux_sel, 1'b1);
    chk("rr_loc", jmp_loc, 16'h0601);
    cyc();
    chk("rr_depth", depth, 3'd0);
    op = NOP; current_address = 16'h0700;
    smp();
    chk("rr_idle_ack", irq_ack, 4'b0);
    cyc();
    smp();
    chk("rr_vec_loc", jmp_loc, 16'hF000);
    chk("rr_vec_ack", irq_ack, 4'b0001);
    chk("rr_vec_depth", depth, 3'd1);
    irq = 4'b0;
    cyc(); cyc();
    do_ret(16'h0701, flag_ex, 0);

    // reset during VECTOR
    irq = 4'b0010;
    cyc();
    smp();
    chk("r6_vec_loc", jmp_loc, 16'hF010);
    reset = 1'b1;
    #1;
    chk("r6_sel", pc_mux_sel, 1'b0);
    chk("r6_loc", jmp_loc, 16'h0);
    chk("r6_ack", irq_ack, 4'b0);
    chk("r6_depth", depth, 3'd0);
    chk("r6_err", stack_err, 1'b0);
    irq = 4'b0;
    cyc();
    reset = 1'b0;
    op = JMP; jmp_address_pm = 16'h1234;
    smp();
    chk("r6_jmp_sel", pc_mux_sel, 1'b1);
    chk("r6_jmp_loc", jmp_loc, 16'h1234);
    chk("r6_jmp_depth", depth, 3'd0);
    cyc();
    take_irq(4'b0010, 1, 16'h0800, 2'b00, 1);
    do_ret(16'h0801, 2'b00, 0);

    // random traffic against the model
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    stk.delete();
    phase = 0;
    merr = 1'b0;
    for (int c = 0; c < 600; c++) begin
      case ($urandom_range(0, 7))
        0: op = JMP;
        1: op = RET;
        2: op = JV;
        3: op = JNV;
        4: op = JZ;
        5: op = JNZ;
        default: op = 6'($urandom);
      endcase
      flag_ex = 2'($urandom);
      irq = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0;
      irq_en = ($urandom_range(0, 3) != 0);
      jmp_address_pm = 16'($urandom);
      current_address = 16'($urandom);
      n = stk.size();

      e_sel = 1'b0; e_loc = jmp_address_pm; lchk = 1'b1;
      e_ack = 4'b0; e_vld = 1'b0; e_fr = 2'b00;
      if (phase == 1) begin
        e_sel = 1'b1;
        e_loc = 16'hF000 + 16'(stk[n-1].chan * 16);
        e_ack = 4'(1 << stk[n-1].chan);
      end else if (phase == 2) begin
        lchk = 1'b0;
      end else begin
        case (op)
          JMP: e_sel = 1'b1;
          JV:  e_sel = flag_ex[0];
          JNV: e_sel = !flag_ex[0];
          JZ:  e_sel = flag_ex[1];
          JNZ: e_sel = !flag_ex[1];
          RET: begin
            if (n > 0) begin
              e_sel = 1'b1; e_loc = stk[n-1].addr;
              e_vld = 1'b1; e_fr = stk[n-1].flags;
            end else lchk = 1'b0;
          end
          default: ;
        endcase
      end

      smp();
      chk("rnd_sel", pc_mux_sel, e_sel);
      if (lchk) chk("rnd_loc", jmp_loc, e_loc);
      chk("rnd_ack", irq_ack, e_ack);
      chk("rnd_vld", flag_restore_vld, e_vld);
      if (e_vld) chk("rnd_flags", flag_restore, e_fr);
      chk("rnd_depth", depth, n);
      chk("rnd_full", stack_full, n == 4);
      chk("rnd_err", stack_err, merr);

      if (phase == 1) begin
        phase = 2;
      end else if (phase == 2) begin
        fr = stk.pop_back();
        fr.flags = flag_ex;
        stk.push_back(fr);
        phase = 0;
      end else if (op == RET) begin
        if (n == 0) merr = 1'b1;
        else void'(stk.pop_back());
      end else if (irq_en && n < 4) begin
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
          if (!found && irq[k] && (n == 0 || k < stk[n-1].chan)) begin
            found = 1'b1;
            fr.addr = current_address + 16'd1;
            fr.flags = 2'b00;
            fr.chan = k;
            stk.push_back(fr);
            phase = 1;
          end
        end
      end
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
